// File: rtl/grf_wb_arbiter.sv
// Register file write-port arbiter: pipeline writeback has priority, and MDU
// results wait in an in-order FIFO until an idle port cycle lets them drain.
// A pending-register scoreboard stalls decode on hazards against
// outstanding MDU results.
module grf_wb_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 2
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          WB_RegWrite,
    input  logic [4:0]    WB_RD,
    input  logic [31:0]   WB_WData,
    input  logic          MD_Issue,
    input  logic [4:0]    MD_IssueRD,
    input  logic          MD_Valid,
    input  logic [4:0]    MD_ResRD,
    input  logic [31:0]   MD_ResData,
    output logic          MD_Ready,
    input  logic [4:0]    ID_RS1,
    input  logic [4:0]    ID_RS2,
    input  logic [4:0]    ID_RD,
    output logic          Stall,
    output logic          RegWrite,
    output logic [4:0]    RD,
    output logic [31:0]   WData,
    output logic [31:0]   Pending,
    output logic [CW-1:0] Count,
    output logic          Conflict
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pending_q, pending_d;
    logic          conflict_q, conflict_d;

    logic          wb_act;
    logic          push;
    logic          pop;
    logic          issue;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign head_rd   = rd_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign wb_act    = WB_RegWrite && (WB_RD != 5'd0);
    assign MD_Ready  = (count_q < CW'(DEPTH));
    // Zero-destination results are handshaken but never stored.
    assign push      = MD_Valid && MD_Ready && (MD_ResRD != 5'd0);
    assign pop       = !wb_act && (count_q != '0);
    assign issue     = MD_Issue && (MD_IssueRD != 5'd0);

    // Write-port mux: writeback first, otherwise the FIFO head.
    always_comb begin
        RegWrite = 1'b0;
        RD       = 5'd0;
        WData    = 32'd0;
        if (wb_act) begin
            RegWrite = 1'b1;
            RD       = WB_RD;
            WData    = WB_WData;
        end else if (pop) begin
            RegWrite = 1'b1;
            RD       = head_rd;
            WData    = head_data;
        end
    end

    // Decode hazard check against registered scoreboard only (no pop look-ahead).
    always_comb begin
        Stall = (pending_q[ID_RS1] && (ID_RS1 != 5'd0)) ||
                (pending_q[ID_RS2] && (ID_RS2 != 5'd0)) ||
                (pending_q[ID_RD]  && (ID_RD  != 5'd0));
    end

    // Next-state for pointers, occupancy, scoreboard and sticky conflict flag.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pending_d  = pending_q;
        conflict_d = conflict_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Clear first so a same-register set in the same cycle wins.
        if (pop) begin
            pending_d[head_rd] = 1'b0;
        end
        if (issue) begin
            pending_d[MD_IssueRD] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (wb_act && pending_q[WB_RD]) begin
            conflict_d = 1'b1;
        end
        if (issue && pending_q[MD_IssueRD] && !(pop && (head_rd == MD_IssueRD))) begin
            conflict_d = 1'b1;
        end
        if (push && !pending_q[MD_ResRD]) begin
            conflict_d = 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            conflict_q <= conflict_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rd_mem_q[i]   <= 5'd0;
                data_mem_q[i] <= 32'd0;
            end
        end else if (push) begin
            rd_mem_q[wr_ptr_q]   <= MD_ResRD;
            data_mem_q[wr_ptr_q] <= MD_ResData;
        end
    end

    assign Pending  = pending_q;
    assign Count    = count_q;
    assign Conflict = conflict_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter. Expected write-port traffic goes into a
// scoreboard queue; a negedge monitor pops and compares on every RegWrite.
module tb_grf_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        WB_RegWrite = 1'b0;
    logic [4:0]  WB_RD = '0;
    logic [31:0] WB_WData = '0;
    logic        MD_Issue = 1'b0;
    logic [4:0]  MD_IssueRD = '0;
    logic        MD_Valid = 1'b0;
    logic [4:0]  MD_ResRD = '0;
    logic [31:0] MD_ResData = '0;
    logic        MD_Ready;
    logic [4:0]  ID_RS1 = '0;
    logic [4:0]  ID_RS2 = '0;
    logic [4:0]  ID_RD = '0;
    logic        Stall;
    logic        RegWrite;
    logic [4:0]  RD;
    logic [31:0] WData;
    logic [31:0] Pending;
    logic [1:0]  Count;
    logic        Conflict;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] sb_q[$];

    grf_wb_arbiter #(.DEPTH(2), .CW(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .WB_RegWrite(WB_RegWrite), .WB_RD(WB_RD), .WB_WData(WB_WData),
        .MD_Issue(MD_Issue), .MD_IssueRD(MD_IssueRD),
        .MD_Valid(MD_Valid), .MD_ResRD(MD_ResRD), .MD_ResData(MD_ResData),
        .MD_Ready(MD_Ready),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
        .Stall(Stall), .RegWrite(RegWrite), .RD(RD), .WData(WData),
        .Pending(Pending), .Count(Count), .Conflict(Conflict)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Write-port monitor.
    always @(negedge Clk) begin
        if (Reset_n === 1'b1 && RegWrite === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL port_unexpected: got rd=%0d data=%h expected no write", RD, WData);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                if ({RD, WData} !== e) begin
                    n_fail++;
                    $display("FAIL port: got rd=%0d data=%h expected rd=%0d data=%h",
                             RD, WData, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        WB_RegWrite = 1'b0; WB_RD = '0; WB_WData = '0;
        MD_Issue = 1'b0; MD_IssueRD = '0;
        MD_Valid = 1'b0; MD_ResRD = '0; MD_ResData = '0;
    endtask

    initial begin
        // Reset state, including the pass-through during reset.
        #2;
        chk("rst_count", 32'(Count), 0);
        chk("rst_pending", Pending, 0);
        chk("rst_ready", 32'(MD_Ready), 1);
        WB_RegWrite = 1'b1; WB_RD = 5'd3; #1;
        chk("rst_regwrite", 32'(RegWrite), 1);
        WB_RegWrite = 1'b0; WB_RD = '0;
        #1 Reset_n = 1'b1;

        // Issue/drain latency with idle writeback.
        sb_q.push_back({5'd5, 32'hDEADBEEF});
        ID_RS1 = 5'd5;
        for (int c = 0; c <= 5; c++) begin
            nxt();
            clr();
            if (c == 0) begin MD_Issue = 1'b1; MD_IssueRD = 5'd5; end
            if (c == 3) begin MD_Valid = 1'b1; MD_ResRD = 5'd5; MD_ResData = 32'hDEADBEEF; end
            @(negedge Clk);
            chk($sformatf("t1_stall_c%0d", c), 32'(Stall), (c >= 1 && c <= 4) ? 1 : 0);
            if (c == 4) chk("t1_count_c4", 32'(Count), 1);
            if (c == 5) begin
                chk("t1_pend5_c5", 32'(Pending[5]), 0);
                chk("t1_count_c5", 32'(Count), 0);
                chk("t1_regwrite_c5", 32'(RegWrite), 0);
            end
        end
        ID_RS1 = '0;

        // Writeback priority over a buffered RD=7.
        for (int i = 0; i < 3; i++) sb_q.push_back({5'd3, 32'h30 + 32'(i)});
        sb_q.push_back({5'd7, 32'h7777});
        for (int c = 0; c <= 6; c++) begin
            nxt();
            clr();
            if (c == 0) begin MD_Issue = 1'b1; MD_IssueRD = 5'd7; end
            if (c == 1) begin MD_Valid = 1'b1; MD_ResRD = 5'd7; MD_ResData = 32'h7777; end
            if (c >= 2 && c <= 4) begin
                WB_RegWrite = 1'b1; WB_RD = 5'd3; WB_WData = 32'h30 + 32'(c - 2);
            end
            @(negedge Clk);
            if (c >= 2 && c <= 5) chk($sformatf("t2_count_c%0d", c), 32'(Count), 1);
            if (c == 6) chk("t2_count_c6", 32'(Count), 0);
        end

        // Full FIFO under continuous writeback.
        for (int i = 0; i < 6; i++) sb_q.push_back({5'd2, 32'h200 + 32'(i)});
        sb_q.push_back({5'd8, 32'h88});
        sb_q.push_back({5'd9, 32'h99});
        for (int c = 0; c <= 8; c++) begin
            nxt();
            clr();
            if (c <= 5) begin WB_RegWrite = 1'b1; WB_RD = 5'd2; WB_WData = 32'h200 + 32'(c); end
            if (c == 0) begin MD_Issue = 1'b1; MD_IssueRD = 5'd8; end
            if (c == 1) begin MD_Issue = 1'b1; MD_IssueRD = 5'd9; end
            if (c == 2) begin MD_Valid = 1'b1; MD_ResRD = 5'd8; MD_ResData = 32'h88; end
            if (c == 3) begin MD_Valid = 1'b1; MD_ResRD = 5'd9; MD_ResData = 32'h99; end
            if (c == 4) begin MD_Valid = 1'b1; MD_ResRD = 5'd10; MD_ResData = 32'hAA; end
            @(negedge Clk);
            if (c == 4) begin
                chk("t3_count_full", 32'(Count), 2);
                chk("t3_ready_full", 32'(MD_Ready), 0);
            end
            if (c == 5) chk("t3_count_hold", 32'(Count), 2);
            if (c == 6) chk("t3_ready_c6", 32'(MD_Ready), 0);
            if (c == 7) begin
                chk("t3_count_c7", 32'(Count), 1);
                chk("t3_ready_c7", 32'(MD_Ready), 1);
            end
            if (c == 8) begin
                chk("t3_count_c8", 32'(Count), 0);
                chk("t3_conflict", 32'(Conflict), 0);
            end
        end

        // WB_RD=0 writeback is an idle port cycle.
        sb_q.push_back({5'd4, 32'h44});
        for (int c = 0; c <= 3; c++) begin
            nxt();
            clr();
            if (c == 0) begin MD_Issue = 1'b1; MD_IssueRD = 5'd4; end
            if (c == 1) begin MD_Valid = 1'b1; MD_ResRD = 5'd4; MD_ResData = 32'h44; end
            if (c >= 2) begin WB_RegWrite = 1'b1; WB_RD = 5'd0; WB_WData = 32'hBAD; end
            @(negedge Clk);
            if (c == 2) chk("t4_count_c2", 32'(Count), 1);
            if (c == 3) begin
                chk("t4_count_c3", 32'(Count), 0);
                chk("t4_regwrite_c3", 32'(RegWrite), 0);
            end
        end

        // Same-cycle set/clear on RD=9, then a genuine re-issue conflict.
        sb_q.push_back({5'd9, 32'h9999});
        for (int c = 0; c <= 4; c++) begin
            nxt();
            clr();
            if (c == 0) begin MD_Issue = 1'b1; MD_IssueRD = 5'd9; end
            if (c == 1) begin MD_Valid = 1'b1; MD_ResRD = 5'd9; MD_ResData = 32'h9999; end
            if (c == 2) begin MD_Issue = 1'b1; MD_IssueRD = 5'd9; end
            if (c == 3) begin MD_Issue = 1'b1; MD_IssueRD = 5'd9; end
            @(negedge Clk);
            if (c == 3) begin
                chk("t5_pend9", 32'(Pending[9]), 1);
                chk("t5_conflict_clean", 32'(Conflict), 0);
                ID_RS2 = 5'd9;
                #1 chk("t5_stall_rs2", 32'(Stall), 1);
                ID_RS2 = 5'd0; ID_RD = 5'd9;
                #1 chk("t5_stall_rd", 32'(Stall), 1);
                ID_RD = 5'd0;
                #1 chk("t5_stall_none", 32'(Stall), 0);
            end
            if (c == 4) chk("t5_conflict_set", 32'(Conflict), 1);
        end

        // Fill to Count=2, Pending=0x300, then assert reset between edges.
        for (int i = 0; i < 3; i++) sb_q.push_back({5'd1, 32'h100 + 32'(i)});
        for (int c = 0; c <= 3; c++) begin
            nxt();
            clr();
            if (c == 0) begin MD_Issue = 1'b1; MD_IssueRD = 5'd8; end
            if (c >= 1) begin WB_RegWrite = 1'b1; WB_RD = 5'd1; WB_WData = 32'h100 + 32'(c - 1); end
            if (c == 1) begin MD_Valid = 1'b1; MD_ResRD = 5'd8; MD_ResData = 32'h8888; end
            if (c == 2) begin MD_Valid = 1'b1; MD_ResRD = 5'd9; MD_ResData = 32'h9191; end
            @(negedge Clk);
            if (c == 3) begin
                chk("t6_count_pre", 32'(Count), 2);
                chk("t6_pending_pre", Pending, 32'h0000_0300);
            end
        end
        nxt();
        clr();
        #2 Reset_n = 1'b0;
        #1;
        chk("t6_count_rst", 32'(Count), 0);
        chk("t6_pending_rst", Pending, 0);
        chk("t6_conflict_rst", 32'(Conflict), 0);
        chk("t6_regwrite_rst", 32'(RegWrite), 0);
        chk("t6_ready_rst", 32'(MD_Ready), 1);
        @(posedge Clk);
        #3 Reset_n = 1'b1;
        nxt();
        @(negedge Clk);
        chk("t6_count_after", 32'(Count), 0);
        chk("t6_regwrite_after", 32'(RegWrite), 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
